// File: rtl/boot_loader_pkg.sv
// rtl/boot_loader_pkg.sv - shared types and constants for the serial program loader
// Contents:
//   boot_state_e : loader FSM states
//   BOOT_HEADER  : frame start byte
//   ERR_*        : values driven on o_error_code
package boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_INSTR_HI,
        ST_INSTR_LO,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } boot_state_e;

    localparam logic [7:0] BOOT_HEADER = 8'hA5;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_FORMAT   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_CHECKSUM = 2'd3;

endpackage

// File: rtl/boot_gap_timer.sv
// rtl/boot_gap_timer.sv - inter-byte gap timer for the serial program loader
// Ports:
//   i_clk, i_reset_n : clock, asynchronous active-low reset
//   i_clear          : byte seen this cycle, reload the counter
//   i_run            : frame in progress, counter may decrement
//   o_expired        : one-cycle pulse on the TIMEOUT_CYCLES-th idle edge
module boot_gap_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Counter is parked at the full value whenever the frame is not running,
    // so the first idle edge after the last byte starts the countdown.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clear || !i_run) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q <= LOAD_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Value 1 means this edge is the TIMEOUT_CYCLES-th edge without a byte.
    assign o_expired = i_run && !i_clear && (cnt_q == ONE);

endmodule

// File: rtl/uart_program_loader.sv
// rtl/uart_program_loader.sv - serial boot loader writing 14-bit words into program memory
// Frame: 0xA5, N, N x {hi, lo}, then a checksum byte when BOOT_CHECKSUM_EN is defined.
// Ports:
//   i_clk, i_reset_n      : clock, asynchronous active-low reset
//   i_rx_valid, i_rx_data : received byte strobe and data from the UART
//   i_restart             : return to IDLE from any state (wins over a same-cycle byte)
//   o_load_enable         : one-cycle program-memory write strobe
//   o_load_address        : write address
//   o_load_instruction    : write data {hi[5:0], lo}
//   o_load_done           : frame written and accepted (level)
//   o_error, o_error_code : frame rejected (level) and reason
// Build option: BOOT_CHECKSUM_EN adds the trailing checksum byte and the CHECK state.
module uart_program_loader
    import boot_loader_pkg::*;
#(
    parameter int PMEM_DEPTH     = 10,
    parameter int ADDR_W         = 8,
    parameter int INSTR_W        = 14,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_rx_valid,
    input  logic [7:0]         i_rx_data,
    input  logic               i_restart,
    output logic               o_load_enable,
    output logic [ADDR_W-1:0]  o_load_address,
    output logic [INSTR_W-1:0] o_load_instruction,
    output logic               o_load_done,
    output logic               o_error,
    output logic [1:0]         o_error_code
);

    boot_state_e        state_q, state_d;
    logic [5:0]         hi_q, hi_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  last_addr_q, last_addr_d;
    logic               we_q, we_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [1:0]         code_q, code_d;
    logic               gap_run;
    logic               gap_expired;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif

    assign gap_run = (state_q == ST_COUNT) || (state_q == ST_INSTR_HI) ||
                     (state_q == ST_INSTR_LO) || (state_q == ST_CHECK);

    boot_gap_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_gap_timer (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_clear   (i_rx_valid),
        .i_run     (gap_run),
        .o_expired (gap_expired)
    );

    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        addr_d      = addr_q;
        last_addr_d = last_addr_q;
        we_d        = 1'b0;
        instr_d     = instr_q;
        code_d      = code_q;
`ifdef BOOT_CHECKSUM_EN
        csum_d      = csum_q;
`endif

        // The address is held for the whole write-strobe cycle and advanced
        // at its end; it stays on the last word so it never passes N-1.
        if (we_q && (addr_q != last_addr_q)) begin
            addr_d = addr_q + ADDR_W'(1);
        end

        if (i_restart) begin
            state_d = ST_IDLE;
            code_d  = ERR_NONE;
        end else if (gap_expired) begin
            state_d = ST_ERROR;
            code_d  = ERR_TIMEOUT;
        end else if (i_rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (i_rx_data == BOOT_HEADER) begin
                        state_d = ST_COUNT;
                        addr_d  = '0;
`ifdef BOOT_CHECKSUM_EN
                        csum_d  = '0;
`endif
                    end
                end
                ST_COUNT: begin
                    if ((i_rx_data == 8'd0) || (int'(i_rx_data) > PMEM_DEPTH)) begin
                        state_d = ST_ERROR;
                        code_d  = ERR_FORMAT;
                    end else begin
                        state_d     = ST_INSTR_HI;
                        addr_d      = '0;
                        last_addr_d = ADDR_W'(i_rx_data - 8'd1);
`ifdef BOOT_CHECKSUM_EN
                        csum_d      = i_rx_data;
`endif
                    end
                end
                ST_INSTR_HI: begin
                    if (i_rx_data[7:6] != 2'b00) begin
                        state_d = ST_ERROR;
                        code_d  = ERR_FORMAT;
                    end else begin
                        state_d = ST_INSTR_LO;
                        hi_d    = i_rx_data[5:0];
`ifdef BOOT_CHECKSUM_EN
                        csum_d  = csum_q ^ i_rx_data;
`endif
                    end
                end
                ST_INSTR_LO: begin
                    we_d    = 1'b1;
                    instr_d = INSTR_W'({hi_q, i_rx_data});
`ifdef BOOT_CHECKSUM_EN
                    csum_d  = csum_q ^ i_rx_data;
                    state_d = (addr_q == last_addr_q) ? ST_CHECK : ST_INSTR_HI;
`else
                    state_d = (addr_q == last_addr_q) ? ST_DONE : ST_INSTR_HI;
`endif
                end
`ifdef BOOT_CHECKSUM_EN
                ST_CHECK: begin
                    if (i_rx_data == csum_q) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ERROR;
                        code_d  = ERR_CHECKSUM;
                    end
                end
`endif
                ST_ERROR: begin
                    if (i_rx_data == BOOT_HEADER) begin
                        state_d = ST_COUNT;
                        code_d  = ERR_NONE;
                        addr_d  = '0;
`ifdef BOOT_CHECKSUM_EN
                        csum_d  = '0;
`endif
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            hi_q        <= '0;
            addr_q      <= '0;
            last_addr_q <= '0;
            we_q        <= 1'b0;
            instr_q     <= '0;
            code_q      <= ERR_NONE;
`ifdef BOOT_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            addr_q      <= addr_d;
            last_addr_q <= last_addr_d;
            we_q        <= we_d;
            instr_q     <= instr_d;
            code_q      <= code_d;
`ifdef BOOT_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign o_load_enable      = we_q;
    assign o_load_address     = addr_q;
    assign o_load_instruction = instr_q;
    assign o_load_done        = (state_q == ST_DONE);
    assign o_error            = (state_q == ST_ERROR);
    assign o_error_code       = code_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// tb/tb_uart_program_loader.sv - self-checking bench for uart_program_loader
module tb_uart_program_loader;

    localparam int DEPTH = 10;
    localparam int AW    = 8;
    localparam int IW    = 14;
    localparam int TMO   = 1024;
`ifdef BOOT_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          restart = 1'b0;
    logic          load_enable;
    logic [AW-1:0] load_address;
    logic [IW-1:0] load_instruction;
    logic          load_done;
    logic          error;
    logic [1:0]    error_code;

    always #5 clk = ~clk;

    uart_program_loader #(
        .PMEM_DEPTH     (DEPTH),
        .ADDR_W         (AW),
        .INSTR_W        (IW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk              (clk),
        .i_reset_n          (rst_n),
        .i_rx_valid         (rx_valid),
        .i_rx_data          (rx_data),
        .i_restart          (restart),
        .o_load_enable      (load_enable),
        .o_load_address     (load_address),
        .o_load_instruction (load_instruction),
        .o_load_done        (load_done),
        .o_error            (error),
        .o_error_code       (error_code)
    );

    int checks = 0;
    int errors = 0;
    int wr_seen = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [IW-1:0] data;
        bit            last;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic [23:0][7:0]   b;
        int                 n;
        int                 nw;
        logic [9:0][AW-1:0] wa;
        logic [9:0][IW-1:0] wd;
        bit                 add_chk;
        bit                 exp_done;
        logic [1:0]         exp_code;
    } vec_t;
    localparam int NV = 7;
    vec_t vt[NV];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every write strobe pops the oldest expected write.
    logic prev_we = 1'b0;
    always @(negedge clk) begin
        if (rst_n && load_enable) begin
            wr_t e;
            wr_seen++;
            check("we_one_cycle", int'(prev_we), 0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected",
                         load_address, load_instruction);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", int'(load_address), int'(e.addr));
                check("wr_data", int'(load_instruction), int'(e.data));
                check("done_with_last_write", int'(load_done), int'(e.last && !CHK));
            end
        end
        prev_we = rst_n && load_enable;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_gap(input logic [7:0] b);
        send_byte(b);
        @(negedge clk);
    endtask

    task automatic pulse_restart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [IW-1:0] d, input bit last);
        wr_t e;
        e.addr = a;
        e.data = d;
        e.last = last;
        exp_q.push_back(e);
    endtask

    // Sends a frame; the checksum is the XOR of every byte after the header.
    task automatic send_frame(input vec_t v);
        logic [7:0] x;
        bit seen;
        x = 8'h00;
        seen = 1'b0;
        for (int i = 0; i < v.n; i++) begin
            if (seen) x = x ^ v.b[i];
            if (v.b[i] == 8'hA5 && !seen) seen = 1'b1;
            send_gap(v.b[i]);
        end
        if (CHK && v.add_chk) send_gap(x);
    endtask

    task automatic put(input int v, input logic [7:0] x);
        vt[v].b[vt[v].n] = x;
        vt[v].n++;
    endtask

    task automatic put_wr(input int v, input logic [AW-1:0] a, input logic [IW-1:0] d);
        vt[v].wa[vt[v].nw] = a;
        vt[v].wd[vt[v].nw] = d;
        vt[v].nw++;
    endtask

    task automatic init_vec(input int v, input bit done, input logic [1:0] code);
        vt[v].b = '0;
        vt[v].n = 0;
        vt[v].nw = 0;
        vt[v].wa = '0;
        vt[v].wd = '0;
        vt[v].add_chk = done;
        vt[v].exp_done = done;
        vt[v].exp_code = code;
    endtask

    initial begin
        int first;
        int wr_before;
        vec_t v;

        init_vec(0, 1'b1, 2'd0);
        put(0, 8'hA5); put(0, 8'h02); put(0, 8'h01); put(0, 8'h23); put(0, 8'h00); put(0, 8'h45);
        put_wr(0, 8'd0, 14'h0123); put_wr(0, 8'd1, 14'h0045);
        init_vec(1, 1'b0, 2'd1);
        put(1, 8'hA5); put(1, 8'h00);
        init_vec(2, 1'b1, 2'd0);
        put(2, 8'hA5); put(2, 8'h01); put(2, 8'h3F); put(2, 8'hFF);
        put_wr(2, 8'd0, 14'h3FFF);
        init_vec(3, 1'b0, 2'd1);
        put(3, 8'hA5); put(3, 8'h01); put(3, 8'h40);
        init_vec(4, 1'b0, 2'd1);
        put(4, 8'hA5); put(4, 8'h0B);
        init_vec(5, 1'b1, 2'd0);
        put(5, 8'h11); put(5, 8'hA5); put(5, 8'h01); put(5, 8'h12); put(5, 8'h34);
        put_wr(5, 8'd0, 14'h1234);
        init_vec(6, 1'b1, 2'd0);
        put(6, 8'hA5); put(6, 8'h0A);
        for (int i = 0; i < 10; i++) begin
            put(6, 8'(i));
            put(6, 8'(8'h10 + i));
            put_wr(6, 8'(i), 14'((i << 8) | (8'h10 + i)));
        end

        repeat (2) @(negedge clk);
        check("reset_outputs", int'({load_enable, load_address, load_instruction,
                                     load_done, error, error_code}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < NV; k++) begin
            v = vt[k];
            pulse_restart();
            check("restart_clears_done", int'(load_done), 0);
            for (int w = 0; w < v.nw; w++) push_wr(v.wa[w], v.wd[w], w == v.nw - 1);
            send_frame(v);
            repeat (3) @(negedge clk);
            check("vec_done", int'(load_done), int'(v.exp_done));
            check("vec_error", int'(error), int'(v.exp_code != 2'd0));
            check("vec_code", int'(error_code), int'(v.exp_code));
            check("vec_writes_drained", exp_q.size(), 0);
        end

        // DONE ignores further bytes.
        wr_before = wr_seen;
        send_gap(8'hA5); send_gap(8'h01); send_gap(8'h12); send_gap(8'h34);
        repeat (2) @(negedge clk);
        check("done_ignores_bytes", wr_seen - wr_before, 0);
        check("done_held", int'(load_done), 1);

        // Async reset mid-frame clears every output at once.
        pulse_restart();
        send_gap(8'hA5); send_gap(8'h03); send_gap(8'h01);
        #2 rst_n = 1'b0;
        #1 check("midframe_reset_outputs", int'({load_enable, load_address, load_instruction,
                                                 load_done, error, error_code}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        vt[0].n = 0; vt[0].nw = 0;
        put(0, 8'hA5); put(0, 8'h01); put(0, 8'h0A); put(0, 8'hBC);
        push_wr(8'd0, 14'h0ABC, 1'b1);
        send_frame(vt[0]);
        repeat (3) @(negedge clk);
        check("after_reset_done", int'(load_done), 1);
        check("after_reset_drained", exp_q.size(), 0);

        // Error then header recovers without restart.
        pulse_restart();
        send_gap(8'hA5); send_gap(8'h00);
        check("fmt_err_code", int'(error_code), 1);
        vt[1].n = 0; vt[1].add_chk = 1'b1;
        put(1, 8'hA5); put(1, 8'h01); put(1, 8'h3F); put(1, 8'hFF);
        push_wr(8'd0, 14'h3FFF, 1'b1);
        send_frame(vt[1]);
        repeat (3) @(negedge clk);
        check("recover_done", int'(load_done), 1);
        check("recover_error_clear", int'(error), 0);

        // Restart and byte in the same cycle: the header is dropped.
        pulse_restart();
        wr_before = wr_seen;
        @(negedge clk);
        rx_valid = 1'b1; rx_data = 8'hA5; restart = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0; restart = 1'b0;
        send_gap(8'h01); send_gap(8'h12); send_gap(8'h34); send_gap(8'h26);
        repeat (2) @(negedge clk);
        check("restart_wins_no_write", wr_seen - wr_before, 0);
        check("restart_wins_no_done", int'(load_done), 0);

        // Restart mid-frame abandons quietly.
        send_gap(8'hA5); send_gap(8'h02); send_gap(8'h01);
        pulse_restart();
        @(negedge clk);
        check("midframe_restart_no_error", int'(error), 0);
        check("midframe_restart_no_write", wr_seen - wr_before, 0);

        // Gap timeout lands exactly TMO edges after the last byte.
        send_gap(8'hA5); send_gap(8'h01);
        send_byte(8'h00);
        first = 0;
        for (int k = 1; k <= TMO + 8; k++) begin
            @(negedge clk);
            if (error && first == 0) first = k;
        end
        check("timeout_cycle", first, TMO);
        check("timeout_code", int'(error_code), 2);

`ifdef BOOT_CHECKSUM_EN
        pulse_restart();
        push_wr(8'd0, 14'h0007, 1'b1);
        send_gap(8'hA5); send_gap(8'h01); send_gap(8'h00); send_gap(8'h07); send_gap(8'h00);
        repeat (2) @(negedge clk);
        check("csum_err_code", int'(error_code), 3);
        check("csum_err_no_done", int'(load_done), 0);
        check("csum_write_kept", exp_q.size(), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
